colour_sequencer: RTL
=====================

Name: colour_sequencer

Overview:
- Controller that sequences the 3-bit colour code and the enable of the registered RGB colour converter (Colour_Converter, 1-cycle latency, colour[2:0] -> rgb[23:0]).
- Supports three modes: auto-cycle with programmable dwell, manual single-step, and one-shot sweep of all 8 codes.
- Also generates rgb_valid, which is aligned to the converter's registered output.
- Sits between user/system control and the converter; it does not touch rgb itself.

Parameters:
- DWELL_W, 8, width of the dwell-time input and internal dwell counter.
- START_COLOUR, 3'b000, colour code loaded on reset and at the start of every run.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- mode  input  2  00 idle, 01 auto-cycle, 10 manual step, 11 sweep-once; sampled only in IDLE
- start  input  1  single-cycle pulse; launches the mode selected on mode
- stop  input  1  single-cycle pulse; aborts any run and returns to IDLE
- step  input  1  single-cycle pulse; advances colour in manual mode
- dwell  input  DWELL_W  cycles each colour is held in auto/sweep; 0 is treated as 1
- colour  output  3  colour code to converter
- conv_en  output  1  converter enable
- rgb_valid  output  1  high when the converter's rgb reflects the current colour (conv_en delayed 1 cycle)
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse when a sweep completes

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, colour=START_COLOUR, conv_en=0, rgb_valid=0, busy=0, done=0, dwell counter=0.
  - Outputs are forced immediately, independent of clk.
  - Release is synchronous to the next clk edge.
- States: IDLE, AUTO, MANUAL, SWEEP, DONE.
- IDLE:
  - conv_en=0; colour holds its last value.
  - start with mode=01 -> AUTO; start with mode=10 -> MANUAL; start with mode=11 -> SWEEP.
  - start with mode=00 is ignored.
  - On every launch: colour<=START_COLOUR, dwell counter<=0, conv_en<=1 in the same edge.
- Dwell rule: eff_dwell = (dwell==0) ? 1 : dwell.
  - Counter increments each cycle.
  - When counter==eff_dwell-1: counter<=0 and colour advances.
  - Each colour is therefore on colour for exactly eff_dwell cycles.
  - dwell is sampled continuously; a change takes effect at the next compare.
- AUTO:
  - colour<=colour+1 mod 8 at each dwell expiry; 3'b111 wraps to 3'b000.
  - Runs until stop.
- MANUAL:
  - Dwell counter idle.
  - step -> colour<=colour+1 mod 8 on that edge, with the same wrap.
  - step held high advances once per cycle.
- SWEEP:
  - Same advance as AUTO.
  - At dwell expiry while colour==3'b111: go to DONE instead of wrapping.
- DONE:
  - One cycle; done=1, conv_en=0, colour stays 3'b111; next state IDLE.
- stop:
  - Takes priority over start, step and dwell expiry in every state.
  - Next state IDLE, conv_en<=0, colour held, no done pulse.
- start while busy is ignored. step outside MANUAL is ignored.
- conv_en=1 in AUTO, MANUAL and SWEEP, 0 otherwise.
- rgb_valid<=conv_en, registered, giving 1-cycle alignment with the converter output register.
- Reset mid-run: immediate return to reset values; no done pulse.
- All outputs are registered.

Decomposition:
- Shared package colour_pkg:
  - state enum / localparams ST_IDLE, ST_AUTO, ST_MANUAL, ST_SWEEP, ST_DONE.
  - mode codes MODE_IDLE, MODE_AUTO, MODE_MANUAL, MODE_SWEEP.
  - 3-bit colour codes BLACK..WHITE, reusable by converter benches.
- One natural sub-module: dwell_timer, a loadable counter producing a one-cycle expiry pulse with the dwell==0 -> 1 rule.
- The top-level bench instantiates colour_sequencer driving Colour_Converter.

Test Plan:
- Reset then idle: rst_n low mid-cycle -> colour=000, conv_en=0, busy=0 immediately; start with mode=00 -> stays IDLE.
- Auto, dwell=3: start -> colour 0,0,0,1,1,1,...; after 24 cycles colour=000 again (wrap); rgb_valid rises 1 cycle after conv_en; converter rgb=FFFFFF while colour=111 with rgb_valid=1.
- Sweep, dwell=0: start -> colour 0..7 one per cycle; done=1 for exactly 1 cycle on cycle 8 after start; busy falls next cycle; conv_en=0 in DONE.
- Manual: start mode=10, three step pulses spaced 5 cycles -> colour 000->001->010->011, unchanged between pulses; 8 steps total wrap to 000.
- Stop priority: in AUTO, assert stop and start together at dwell expiry -> IDLE, colour not advanced, no done, conv_en=0 next cycle.
- Async reset mid-sweep at colour=101 -> all outputs to reset values without a clk edge; no done pulse.

Source files
------------

// File: rtl/colour_pkg.sv
// Shared types and codes for the colour sequencer and the benches around it.
package colour_pkg;

  localparam int unsigned COLOUR_W = 3;
  localparam int unsigned MODE_W   = 2;

  typedef logic [COLOUR_W-1:0] colour_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_AUTO   = 3'd1,
    ST_MANUAL = 3'd2,
    ST_SWEEP  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam logic [MODE_W-1:0] MODE_IDLE   = 2'b00;
  localparam logic [MODE_W-1:0] MODE_AUTO   = 2'b01;
  localparam logic [MODE_W-1:0] MODE_MANUAL = 2'b10;
  localparam logic [MODE_W-1:0] MODE_SWEEP  = 2'b11;

  // Colour codes as consumed by the converter: bit2=R, bit1=G, bit0=B.
  localparam colour_t BLACK   = 3'b000;
  localparam colour_t BLUE    = 3'b001;
  localparam colour_t GREEN   = 3'b010;
  localparam colour_t CYAN    = 3'b011;
  localparam colour_t RED     = 3'b100;
  localparam colour_t MAGENTA = 3'b101;
  localparam colour_t YELLOW  = 3'b110;
  localparam colour_t WHITE   = 3'b111;

  function automatic colour_t next_colour(input colour_t c);
    return c + colour_t'(1);
  endfunction

  function automatic logic is_running(input state_e s);
    return (s == ST_AUTO) || (s == ST_MANUAL) || (s == ST_SWEEP);
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Loadable dwell counter; expire_c pulses on the last cycle of each dwell
// period, with a programmed dwell of zero behaving as one.
module dwell_timer #(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_i,
  input  logic               run_i,
  input  logic [DWELL_W-1:0] dwell_i,
  output logic               expire_c
);

  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] eff_c, last_c;

  assign eff_c    = (dwell_i == '0) ? DWELL_W'(1) : dwell_i;
  assign last_c   = eff_c - DWELL_W'(1);
  assign expire_c = run_i && !clear_i && (cnt_q == last_c);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = expire_c ? '0 : cnt_q + DWELL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/colour_sequencer.sv
// Drives the colour code and enable of the registered RGB converter in
// auto-cycle, manual-step and one-shot sweep modes; all outputs registered.
module colour_sequencer
  import colour_pkg::*;
#(
  parameter int unsigned          DWELL_W      = 8,
  parameter logic [COLOUR_W-1:0]  START_COLOUR = 3'b000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [MODE_W-1:0]   mode,
  input  logic                start,
  input  logic                stop,
  input  logic                step,
  input  logic [DWELL_W-1:0]  dwell,
  output logic [COLOUR_W-1:0] colour,
  output logic                conv_en,
  output logic                rgb_valid,
  output logic                busy,
  output logic                done
);

  state_e  st_q, st_d;
  colour_t colour_q, colour_d;
  logic    conv_en_q, conv_en_d;
  logic    rgb_valid_q, rgb_valid_d;
  logic    busy_q, busy_d;
  logic    done_q, done_d;
  logic    launch_c;
  logic    timer_run_c;
  logic    expire_c;

  assign timer_run_c = (st_q == ST_AUTO) || (st_q == ST_SWEEP);
  assign launch_c    = (st_q == ST_IDLE) && (st_d != ST_IDLE);

  dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_dwell_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (launch_c),
    .run_i    (timer_run_c),
    .dwell_i  (dwell),
    .expire_c (expire_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= ST_IDLE;
    end else begin
      st_q <= st_d;
    end
  end

  // Next state; stop overrides every other request.
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      ST_IDLE: begin
        if (start) begin
          unique case (mode)
            MODE_AUTO:   st_d = ST_AUTO;
            MODE_MANUAL: st_d = ST_MANUAL;
            MODE_SWEEP:  st_d = ST_SWEEP;
            MODE_IDLE:   st_d = ST_IDLE;
            default:     st_d = ST_IDLE;
          endcase
        end
      end
      ST_AUTO:   st_d = ST_AUTO;
      ST_MANUAL: st_d = ST_MANUAL;
      ST_SWEEP: begin
        if (expire_c && (colour_q == WHITE)) begin
          st_d = ST_DONE;
        end
      end
      ST_DONE:   st_d = ST_IDLE;
      default:   st_d = ST_IDLE;
    endcase
    if (stop) begin
      st_d = ST_IDLE;
    end
  end

  // Registered-output next values, derived from the state being entered.
  always_comb begin
    colour_d    = colour_q;
    conv_en_d   = is_running(st_d);
    busy_d      = (st_d != ST_IDLE);
    done_d      = (st_d == ST_DONE);
    rgb_valid_d = conv_en_q;
    if (launch_c) begin
      colour_d = START_COLOUR;
    end else if (!stop) begin
      unique case (st_q)
        ST_AUTO: begin
          if (expire_c) colour_d = next_colour(colour_q);
        end
        ST_SWEEP: begin
          if (expire_c && (colour_q != WHITE)) colour_d = next_colour(colour_q);
        end
        ST_MANUAL: begin
          if (step) colour_d = next_colour(colour_q);
        end
        default: colour_d = colour_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      colour_q    <= START_COLOUR;
      conv_en_q   <= 1'b0;
      rgb_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      colour_q    <= colour_d;
      conv_en_q   <= conv_en_d;
      rgb_valid_q <= rgb_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign colour    = colour_q;
  assign conv_en   = conv_en_q;
  assign rgb_valid = rgb_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
